glyph_rom_arbiter: RTL
======================

// Module: glyph_rom_arbiter
// PURPOSE
//  Shares one synchronous 8x8 character-glyph ROM between two pixel sources.
//  Port A is the scrolling FizzBuzz text line; port B is the big bouncing word renderer.
//  Sequences one lookup per cycle, tags each in-flight lookup with its owner,
//  and returns registered glyph rows to the owning requester.
//  Sits between the per-pixel char mapping logic and the chars ROM.
// PARAMETERS
//  CHAR_W      4  glyph index width
//  ROW_W       3  glyph row-select width
//  PIX_W       8  glyph row width (pixels)
//  PRIORITY_A  0  0 = round-robin between A and B; 1 = A wins, with B anti-starvation
//  MAX_WAIT    4  PRIORITY_A=1 only: consecutive B-losing cycles before B is forced (>=1)
// PORTS
//  clk         in   1       system clock (50 MHz)
//  rst_n       in   1       asynchronous reset, active low
//  a_req       in   1       A lookup request
//  a_char      in   CHAR_W  A glyph index
//  a_row       in   ROW_W   A glyph row
//  a_gnt       out  1       A granted this cycle (combinational)
//  a_valid     out  1       a_pixels holds an A result (1-cycle pulse per grant)
//  a_pixels    out  PIX_W   A glyph row, MSB = leftmost pixel
//  b_req       in   1       B lookup request
//  b_char      in   CHAR_W  B glyph index
//  b_row       in   ROW_W   B glyph row
//  b_gnt       out  1       B granted this cycle (combinational)
//  b_valid     out  1       b_pixels holds a B result (1-cycle pulse per grant)
//  b_pixels    out  PIX_W   B glyph row
//  rom_en      out  1       ROM read strobe (= a_gnt | b_gnt)
//  rom_char    out  CHAR_W  ROM glyph index (granted requester's; 0 when idle)
//  rom_row     out  ROW_W   ROM row (granted requester's; 0 when idle)
//  rom_pixels  in   PIX_W   ROM data, valid the cycle after rom_en
//  b_starved   out  1       registered; high while B wait counter == MAX_WAIT
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - a_valid = b_valid = 0; a_pixels = b_pixels = 0; b_starved = 0
//   - tag pipeline cleared; last_grant = B (A wins first contention); wait counter = 0
//  Arbitration, cycle N, combinational:
//   - at most one of a_gnt/b_gnt is high
//   - a grant only goes to an asserting req
//   - single requester: granted
//   - both, PRIORITY_A=0: grant the requester not in last_grant
//   - both, PRIORITY_A=1: grant A, unless wait counter == MAX_WAIT, then grant B
//   - last_grant updates on every grant; unchanged on idle cycles
//  Requester rules:
//   - an ungranted requester holds char/row stable, or deasserts req to abandon
//   - abandoning is legal and produces no result
//  Pipeline:
//   - stage 1 tag: registers {granted_a, granted_b} at end of N
//   - cycle N+1: rom_pixels is routed to the tagged port's pixel register
//   - cycle N+2: x_valid=1 and x_pixels=glyph; latency req->valid = 2 cycles
//   - x_pixels holds its last value until the next result for that port
//   - throughput: 1 lookup/cycle total; back-to-back and alternating grants are legal
//   - results always return in grant order
//  Wait counter (PRIORITY_A=1; held at 0 when PRIORITY_A=0):
//   - +1 on each cycle b_req=1 and b_gnt=0
//   - saturates at MAX_WAIT
//   - cleared on b_gnt or b_req=0
//   - b_starved = registered (counter == MAX_WAIT)
//  Reset mid-operation: in-flight lookups are discarded; no valid pulse after rst_n rises
//   until new grants complete.
//  Widths: counter is $clog2(MAX_WAIT+1) bits; no truncation of char/row/pixels.
// TESTING
//  1. rst_n=0 while ROM busy
//     -> all valids/pixels 0 immediately (async); no stray valid after release.
//  2. A only, a_char=5, a_row=2, ROM returns 8'h3C
//     -> a_gnt same cycle, rom_char=5, rom_row=2; a_valid with a_pixels=8'h3C two cycles
//        later; b_valid stays 0.
//  3. PRIORITY_A=0, both req for 6 cycles
//     -> grants A,B,A,B,A,B; valids alternate with matching pixels, in order.
//  4. PRIORITY_A=1, MAX_WAIT=4, both req continuously
//     -> A granted 4 cycles; b_starved high; B granted on cycle 5; counter clears; A resumes.
//  5. B drops req after 2 losing cycles
//     -> no B result; counter returns to 0; b_starved never asserts.
//  6. No requests
//     -> rom_en=0, rom_char=rom_row=0; no valid pulses; pixel outputs hold previous values.

Source files
------------

// File: rtl/glyph_rom_arbiter.sv
// Arbitrates two pixel sources onto one synchronous glyph ROM and returns each
// registered glyph row to the requester that owned the lookup.
module glyph_rom_arbiter #(
  parameter int CHAR_W     = 4,
  parameter int ROW_W      = 3,
  parameter int PIX_W      = 8,
  parameter int PRIORITY_A = 0,
  parameter int MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [CHAR_W-1:0] a_char,
  input  logic [ROW_W-1:0]  a_row,
  output logic              a_gnt,
  output logic              a_valid,
  output logic [PIX_W-1:0]  a_pixels,
  input  logic              b_req,
  input  logic [CHAR_W-1:0] b_char,
  input  logic [ROW_W-1:0]  b_row,
  output logic              b_gnt,
  output logic              b_valid,
  output logic [PIX_W-1:0]  b_pixels,
  output logic              rom_en,
  output logic [CHAR_W-1:0] rom_char,
  output logic [ROW_W-1:0]  rom_row,
  input  logic [PIX_W-1:0]  rom_pixels,
  output logic              b_starved
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic {GRANT_A, GRANT_B} owner_e;

  owner_e           last_grant;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             tag_a;
  logic             tag_b;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (a_req && b_req) begin
      if (PRIORITY_A != 0) begin
        if (wait_cnt == WAIT_MAX) b_gnt = 1'b1;
        else                      a_gnt = 1'b1;
      end else if (last_grant == GRANT_B) begin
        a_gnt = 1'b1;
      end else begin
        b_gnt = 1'b1;
      end
    end else begin
      a_gnt = a_req;
      b_gnt = b_req;
    end
  end

  // ROM address is forced to zero when idle so the bus stays quiet.
  always_comb begin
    rom_en   = a_gnt | b_gnt;
    rom_char = '0;
    rom_row  = '0;
    if (a_gnt) begin
      rom_char = a_char;
      rom_row  = a_row;
    end else if (b_gnt) begin
      rom_char = b_char;
      rom_row  = b_row;
    end
  end

  // B loses only while both request; any B grant or B withdrawal restarts it.
  always_comb begin
    wait_cnt_next = '0;
    if (PRIORITY_A != 0 && b_req && !b_gnt) begin
      wait_cnt_next = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_B;
      wait_cnt   <= '0;
      b_starved  <= 1'b0;
      tag_a      <= 1'b0;
      tag_b      <= 1'b0;
      a_valid    <= 1'b0;
      b_valid    <= 1'b0;
      a_pixels   <= '0;
      b_pixels   <= '0;
    end else begin
      if (a_gnt)      last_grant <= GRANT_A;
      else if (b_gnt) last_grant <= GRANT_B;
      wait_cnt  <= wait_cnt_next;
      b_starved <= (wait_cnt_next == WAIT_MAX);
      // Tag travels alongside the ROM's own one-cycle read latency.
      tag_a   <= a_gnt;
      tag_b   <= b_gnt;
      a_valid <= tag_a;
      b_valid <= tag_b;
      if (tag_a) a_pixels <= rom_pixels;
      if (tag_b) b_pixels <= rom_pixels;
    end
  end

endmodule
